// File: rtl/field_sync_monitor_pkg.sv
// Shared constants for the field/VSYNC diagnostic monitor.
//   CNT_W_DEF   : default width of the counters and the delta.
//   NUM_EVT_DEF : default number of latched event inputs.
//   EVT_*       : bit positions of the event inputs as wired in the top level.
package field_sync_monitor_pkg;

    localparam int CNT_W_DEF   = 16;
    localparam int NUM_EVT_DEF = 4;

    localparam int EVT_LOCK_LOST   = 0;
    localparam int EVT_RESYNC      = 1;
    localparam int EVT_FRAME_MISS  = 2;
    localparam int EVT_MARKER_MISS = 3;

endpackage

// File: rtl/field_sync_monitor_if.sv
// Bus bundle between the monitor and its environment.
//   master : drives src_toggle, dst_toggle_async, evt_level, stat_clear;
//            observes the counters, delta statistics, event flags and slip count.
//   slave  : the monitor side of the same signals.
interface field_sync_monitor_if
    import field_sync_monitor_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int NUM_EVT = NUM_EVT_DEF
);
    logic               src_toggle;
    logic               dst_toggle_async;
    logic [NUM_EVT-1:0] evt_level;
    logic               stat_clear;

    logic [CNT_W-1:0]   src_cnt;
    logic [CNT_W-1:0]   dst_cnt;
    logic [CNT_W-1:0]   delta;
    logic [CNT_W-1:0]   delta_min;
    logic [CNT_W-1:0]   delta_max;
    logic [NUM_EVT-1:0] evt_live;
    logic [NUM_EVT-1:0] evt_snap;
    logic               window_done;
    logic [CNT_W-1:0]   slip_cnt;

    modport master (
        output src_toggle, dst_toggle_async, evt_level, stat_clear,
        input  src_cnt, dst_cnt, delta, delta_min, delta_max,
               evt_live, evt_snap, window_done, slip_cnt
    );

    modport slave (
        input  src_toggle, dst_toggle_async, evt_level, stat_clear,
        output src_cnt, dst_cnt, delta, delta_min, delta_max,
               evt_live, evt_snap, window_done, slip_cnt
    );

endinterface

// File: rtl/field_sync_monitor_toggle_sync_edge.sv
// Synchronises a toggle from a foreign clock domain and emits a one-cycle
// pulse per toggle edge.
//   clk    : local clock.
//   resetn : asynchronous active-low reset.
//   tog_i  : asynchronous toggle input.
//   edge_o : one-cycle pulse, high in the cycle a synchronised edge is seen.
module field_sync_monitor_toggle_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic tog_i,
    output logic edge_o
);
    localparam int FILL_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic [FILL_W-1:0] fill_q;
    logic              armed_q;

    // Arming waits until the chain and prev_q both hold post-reset samples,
    // so the reset-zero to live-level transition is never taken as an edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            fill_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], tog_i};
            prev_q <= sync_q[STAGES-1];
            if (!armed_q) begin
                if (fill_q == FILL_W'(STAGES)) begin
                    armed_q <= 1'b1;
                end else begin
                    fill_q <= fill_q + FILL_W'(1);
                end
            end
        end
    end

    assign edge_o = armed_q & (sync_q[STAGES-1] ^ prev_q);

endmodule

// File: rtl/field_sync_monitor.sv
// Field-start versus output-VSYNC monitor in the cam1_pclk domain.
// Counts local field toggles and synchronised VSYNC toggles, tracks their
// modular difference with boundary-sampled min/max and slip detection, and
// latches event levels into per-window sticky flags with a boundary snapshot.
//   clk    : monitor clock.
//   resetn : asynchronous active-low reset.
//   bus    : slave side of field_sync_monitor_if (toggles, events, clear in;
//            counters, delta statistics, event flags, window_done, slip_cnt out).
module field_sync_monitor
    import field_sync_monitor_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int NUM_EVT     = NUM_EVT_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int SLIP_THRESH = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    field_sync_monitor_if.slave  bus
);
    logic                      src_d_q, src_armed_q;
    logic                      src_edge, dst_edge;
    logic [CNT_W-1:0]          src_cnt_q, src_cnt_d, dst_cnt_q, dst_cnt_d;
    logic [CNT_W-1:0]          slip_q, slip_d;
    logic signed [CNT_W-1:0]   delta_q, delta_d, dmin_q, dmin_d, dmax_q, dmax_d;
    logic signed [CNT_W-1:0]   dref_q, dref_d;
    logic                      first_q, first_d, wd_q;
    logic [NUM_EVT-1:0]        live_q, live_d, snap_q, snap_d;

    // |cur - ref_v| >= SLIP_THRESH, evaluated one bit wider so the difference
    // of two extreme signed values cannot overflow.
    function automatic logic slip_hit(input logic signed [CNT_W-1:0] cur,
                                      input logic signed [CNT_W-1:0] ref_v);
        logic signed [CNT_W:0] diff;
        diff = {cur[CNT_W-1], cur} - {ref_v[CNT_W-1], ref_v};
        if (diff[CNT_W]) diff = -diff;
        return (diff >= (CNT_W+1)'(SLIP_THRESH));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    field_sync_monitor_toggle_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_dst_sync (
        .clk    (clk),
        .resetn (resetn),
        .tog_i  (bus.dst_toggle_async),
        .edge_o (dst_edge)
    );

    // src_armed_q blocks the first cycle, so a level present at reset
    // release is never counted.
    assign src_edge = src_armed_q & (bus.src_toggle ^ src_d_q);

    always_comb begin
        src_cnt_d = src_cnt_q;
        dst_cnt_d = dst_cnt_q;
        delta_d   = src_cnt_q - dst_cnt_q;
        dmin_d    = dmin_q;
        dmax_d    = dmax_q;
        dref_d    = dref_q;
        first_d   = first_q;
        slip_d    = slip_q;
        live_d    = live_q | bus.evt_level;
        snap_d    = snap_q;

        if (src_edge) src_cnt_d = src_cnt_q + CNT_W'(1);
        if (dst_edge) dst_cnt_d = dst_cnt_q + CNT_W'(1);

        if (dst_edge) begin
            snap_d = live_q | bus.evt_level;
            live_d = bus.evt_level;
            if (first_q) begin
                dmin_d  = delta_q;
                dmax_d  = delta_q;
                dref_d  = delta_q;
                first_d = 1'b0;
            end else begin
                if (delta_q < dmin_q) dmin_d = delta_q;
                if (delta_q > dmax_q) dmax_d = delta_q;
                if (slip_hit(delta_q, dref_q)) slip_d = sat_inc(slip_q);
                dref_d = delta_q;
            end
        end

        // A clear overrides the boundary's statistics update; the window
        // still rolls over so the current event level is kept.
        if (bus.stat_clear) begin
            slip_d  = '0;
            snap_d  = '0;
            first_d = 1'b1;
            dmin_d  = dmin_q;
            dmax_d  = dmax_q;
            dref_d  = dref_q;
            live_d  = dst_edge ? bus.evt_level : '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            src_d_q     <= 1'b0;
            src_armed_q <= 1'b0;
            src_cnt_q   <= '0;
            dst_cnt_q   <= '0;
            delta_q     <= '0;
            dmin_q      <= '0;
            dmax_q      <= '0;
            dref_q      <= '0;
            first_q     <= 1'b1;
            slip_q      <= '0;
            live_q      <= '0;
            snap_q      <= '0;
            wd_q        <= 1'b0;
        end else begin
            src_d_q     <= bus.src_toggle;
            src_armed_q <= 1'b1;
            src_cnt_q   <= src_cnt_d;
            dst_cnt_q   <= dst_cnt_d;
            delta_q     <= delta_d;
            dmin_q      <= dmin_d;
            dmax_q      <= dmax_d;
            dref_q      <= dref_d;
            first_q     <= first_d;
            slip_q      <= slip_d;
            live_q      <= live_d;
            snap_q      <= snap_d;
            wd_q        <= dst_edge;
        end
    end

    assign bus.src_cnt     = src_cnt_q;
    assign bus.dst_cnt     = dst_cnt_q;
    assign bus.delta       = delta_q;
    assign bus.delta_min   = dmin_q;
    assign bus.delta_max   = dmax_q;
    assign bus.evt_live    = live_q;
    assign bus.evt_snap    = snap_q;
    assign bus.window_done = wd_q;
    assign bus.slip_cnt    = slip_q;

endmodule

// File: tb/tb_field_sync_monitor.sv
module tb_field_sync_monitor;
    import field_sync_monitor_pkg::*;

    localparam int S   = 2;
    localparam int NE  = 4;
    localparam int W_A = 16;
    localparam int W_B = 4;
    localparam int TH_A = 1;
    localparam int TH_B = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic          s_tog, d_tog, clr;
    logic [NE-1:0] ev;
    bit            chk_en = 1'b0;
    int            n_cmp = 0;
    int            n_fail = 0;

    field_sync_monitor_if #(.CNT_W(W_A), .NUM_EVT(NE)) bus_a ();
    field_sync_monitor_if #(.CNT_W(W_B), .NUM_EVT(NE)) bus_b ();

    assign bus_a.src_toggle = s_tog;  assign bus_b.src_toggle = s_tog;
    assign bus_a.dst_toggle_async = d_tog;  assign bus_b.dst_toggle_async = d_tog;
    assign bus_a.evt_level = ev;  assign bus_b.evt_level = ev;
    assign bus_a.stat_clear = clr;  assign bus_b.stat_clear = clr;

    field_sync_monitor #(.CNT_W(W_A), .NUM_EVT(NE), .SYNC_STAGES(S), .SLIP_THRESH(TH_A))
        dut_a (.clk(clk), .resetn(resetn), .bus(bus_a));
    field_sync_monitor #(.CNT_W(W_B), .NUM_EVT(NE), .SYNC_STAGES(S), .SLIP_THRESH(TH_B))
        dut_b (.clk(clk), .resetn(resetn), .bus(bus_b));

    // ---------------- reference model (history based) ----------------
    typedef struct {
        int        n;
        bit        s_prev;
        bit [7:0]  dh;      // dh[k] = dst input sampled k clocks ago
        int        src, dst, delta, dmin, dmax, dref, slip;
        bit        first;
        bit [NE-1:0] live, snap;
        bit        wd;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r = '{default: 0};
        r.first = 1'b1;
        return r;
    endfunction

    function automatic int sx(int v, int w);
        return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int w, int th, bit s, bit d,
                                      bit [NE-1:0] e, bit c);
        mdl_t r = m;
        int   mask = (1 << w) - 1;
        int   cur, dd;
        bit   se, de;
        r.n = m.n + 1;
        // A source edge is any change between two post-reset samples.
        se = (r.n >= 2) && (s != m.s_prev);
        r.s_prev = s;
        r.dh = {m.dh[6:0], d};
        // A change seen at sample k shows up S clocks later in dst_cnt.
        de = (r.n - S >= 2) && (r.dh[S] != r.dh[S+1]);
        r.src   = (m.src + int'(se)) & mask;
        r.dst   = (m.dst + int'(de)) & mask;
        r.delta = (m.src - m.dst) & mask;
        r.wd    = de;
        r.live  = m.live | e;
        if (de) begin
            r.snap = m.live | e;
            r.live = e;
            cur = sx(m.delta, w);
            if (m.first) begin
                r.dmin = cur; r.dmax = cur; r.dref = cur; r.first = 1'b0;
            end else begin
                if (cur < m.dmin) r.dmin = cur;
                if (cur > m.dmax) r.dmax = cur;
                dd = cur - m.dref;
                if (dd < 0) dd = -dd;
                if (dd >= th && m.slip != mask) r.slip = m.slip + 1;
                r.dref = cur;
            end
        end
        if (c) begin
            r.slip = 0; r.snap = '0; r.first = 1'b1;
            r.dmin = m.dmin; r.dmax = m.dmax; r.dref = m.dref;
            r.live = de ? e : '0;
        end
        return r;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ma <= mdl_reset();
            mb <= mdl_reset();
        end else begin
            ma <= mdl_step(ma, W_A, TH_A, s_tog, d_tog, ev, clr);
            mb <= mdl_step(mb, W_B, TH_B, s_tog, d_tog, ev, clr);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string tag, input int w, input mdl_t m,
                            input logic [31:0] sc, dc, dl, mn, mx, lv, sn, wd, sl);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        check({tag, ".src_cnt"},     sc, m.src & mask);
        check({tag, ".dst_cnt"},     dc, m.dst & mask);
        check({tag, ".delta"},       dl, m.delta & mask);
        check({tag, ".delta_min"},   mn, m.dmin & mask);
        check({tag, ".delta_max"},   mx, m.dmax & mask);
        check({tag, ".evt_live"},    lv, 32'(m.live));
        check({tag, ".evt_snap"},    sn, 32'(m.snap));
        check({tag, ".window_done"}, wd, 32'(m.wd));
        check({tag, ".slip_cnt"},    sl, m.slip & mask);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst("mdl_a", W_A, ma, 32'(bus_a.src_cnt), 32'(bus_a.dst_cnt), 32'(bus_a.delta),
                     32'(bus_a.delta_min), 32'(bus_a.delta_max), 32'(bus_a.evt_live),
                     32'(bus_a.evt_snap), 32'(bus_a.window_done), 32'(bus_a.slip_cnt));
            cmp_inst("mdl_b", W_B, mb, 32'(bus_b.src_cnt), 32'(bus_b.dst_cnt), 32'(bus_b.delta),
                     32'(bus_b.delta_min), 32'(bus_b.delta_max), 32'(bus_b.evt_live),
                     32'(bus_b.evt_snap), 32'(bus_b.window_done), 32'(bus_b.slip_cnt));
        end
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".a_src"},   32'(bus_a.src_cnt), 0);
        check({tag, ".a_dst"},   32'(bus_a.dst_cnt), 0);
        check({tag, ".a_delta"}, 32'(bus_a.delta), 0);
        check({tag, ".a_min"},   32'(bus_a.delta_min), 0);
        check({tag, ".a_max"},   32'(bus_a.delta_max), 0);
        check({tag, ".a_live"},  32'(bus_a.evt_live), 0);
        check({tag, ".a_snap"},  32'(bus_a.evt_snap), 0);
        check({tag, ".a_wd"},    32'(bus_a.window_done), 0);
        check({tag, ".a_slip"},  32'(bus_a.slip_cnt), 0);
        check({tag, ".b_src"},   32'(bus_b.src_cnt), 0);
        check({tag, ".b_live"},  32'(bus_b.evt_live), 0);
        check({tag, ".b_slip"},  32'(bus_b.slip_cnt), 0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit        s, d;
        bit [3:0]  ev;
        bit        c;
        logic [15:0] dcnt;
        bit        wd;
        logic [15:0] dl;
        bit [3:0]  lv, sn;
        logic [15:0] mn, mx, sl;
    } vec_t;

    vec_t tbl [9];
    bit   wd_seen;

    initial begin
        // One dst toggle (edge on the 3rd clock), events mid-window and in the
        // boundary cycle, then a second toggle that produces a slip of 1.
        tbl[0] = '{1'b1, 1'b0, 4'h0, 1'b0, 16'd0, 1'b0, 16'h0000, 4'h0, 4'h0, 16'h0000, 16'h0, 16'd0};
        tbl[1] = '{1'b1, 1'b0, 4'h1, 1'b0, 16'd0, 1'b0, 16'h0000, 4'h1, 4'h0, 16'h0000, 16'h0, 16'd0};
        tbl[2] = '{1'b1, 1'b0, 4'h2, 1'b0, 16'd1, 1'b1, 16'h0000, 4'h2, 4'h3, 16'h0000, 16'h0, 16'd0};
        tbl[3] = '{1'b1, 1'b0, 4'h0, 1'b0, 16'd1, 1'b0, 16'hFFFF, 4'h2, 4'h3, 16'h0000, 16'h0, 16'd0};
        tbl[4] = '{1'b1, 1'b0, 4'h0, 1'b0, 16'd1, 1'b0, 16'hFFFF, 4'h2, 4'h3, 16'h0000, 16'h0, 16'd0};
        tbl[5] = '{1'b1, 1'b1, 4'h0, 1'b0, 16'd1, 1'b0, 16'hFFFF, 4'h2, 4'h3, 16'h0000, 16'h0, 16'd0};
        tbl[6] = '{1'b1, 1'b1, 4'h0, 1'b0, 16'd1, 1'b0, 16'hFFFF, 4'h2, 4'h3, 16'h0000, 16'h0, 16'd0};
        tbl[7] = '{1'b1, 1'b1, 4'h0, 1'b0, 16'd2, 1'b1, 16'hFFFF, 4'h0, 4'h2, 16'hFFFF, 16'h0, 16'd1};
        tbl[8] = '{1'b1, 1'b1, 4'h0, 1'b0, 16'd2, 1'b0, 16'hFFFE, 4'h0, 4'h2, 16'hFFFF, 16'h0, 16'd1};

        s_tog = 1'b1; d_tog = 1'b1; ev = '0; clr = 1'b0; resetn = 1'b0;
        tick(3);
        check_all_zero("reset");

        // Levels high at release must never count.
        resetn = 1'b1;
        chk_en = 1'b1;
        wd_seen = 1'b0;
        repeat (50) begin
            tick(1);
            if (bus_a.window_done) wd_seen = 1'b1;
        end
        check("idle.src_cnt", 32'(bus_a.src_cnt), 0);
        check("idle.dst_cnt", 32'(bus_a.dst_cnt), 0);
        check("idle.wd_seen", 32'(wd_seen), 0);

        for (int i = 0; i < 9; i++) begin
            s_tog = tbl[i].s; d_tog = tbl[i].d; ev = tbl[i].ev; clr = tbl[i].c;
            tick(1);
            check($sformatf("tbl%0d.dst_cnt", i),     32'(bus_a.dst_cnt),     32'(tbl[i].dcnt));
            check($sformatf("tbl%0d.window_done", i), 32'(bus_a.window_done), 32'(tbl[i].wd));
            check($sformatf("tbl%0d.delta", i),       32'(bus_a.delta),       32'(tbl[i].dl));
            check($sformatf("tbl%0d.evt_live", i),    32'(bus_a.evt_live),    32'(tbl[i].lv));
            check($sformatf("tbl%0d.evt_snap", i),    32'(bus_a.evt_snap),    32'(tbl[i].sn));
            check($sformatf("tbl%0d.delta_min", i),   32'(bus_a.delta_min),   32'(tbl[i].mn));
            check($sformatf("tbl%0d.delta_max", i),   32'(bus_a.delta_max),   32'(tbl[i].mx));
            check($sformatf("tbl%0d.slip_cnt", i),    32'(bus_a.slip_cnt),    32'(tbl[i].sl));
        end

        // stat_clear in the dst_edge cycle, with an event present.
        d_tog = 1'b0;
        tick(2);
        clr = 1'b1; ev = 4'h4;
        tick(1);
        clr = 1'b0; ev = 4'h0;
        check("clr.window_done", 32'(bus_a.window_done), 1);
        check("clr.slip_cnt",    32'(bus_a.slip_cnt), 0);
        check("clr.evt_snap",    32'(bus_a.evt_snap), 0);
        check("clr.evt_live",    32'(bus_a.evt_live), 4);
        d_tog = 1'b1;
        tick(3);
        check("reinit.window_done", 32'(bus_a.window_done), 1);
        check("reinit.delta_min",   32'(bus_a.delta_min), 32'hFFFD);
        check("reinit.delta_max",   32'(bus_a.delta_max), 32'hFFFD);
        check("reinit.evt_snap",    32'(bus_a.evt_snap), 4);
        check("reinit.slip_cnt",    32'(bus_a.slip_cnt), 0);

        // Asynchronous reset in the middle of a window.
        ev = 4'h8;
        tick(2);
        ev = 4'h0;
        @(posedge clk);
        #2 resetn = 1'b0;
        #1 check_all_zero("midrst");
        tick(2);
        resetn = 1'b1;
        tick(5);

        // Interleaved toggles: src leads dst by one field.
        for (int i = 0; i < 10; i++) begin
            s_tog = ~s_tog;
            tick(2);
            d_tog = ~d_tog;
            for (int k = 0; k < 6; k++) begin
                tick(1);
                check($sformatf("ilv%0d.delta_in_0_1", i),
                      32'(bus_a.delta == 16'd0 || bus_a.delta == 16'd1), 1);
            end
        end
        check("ilv.slip_cnt",  32'(bus_a.slip_cnt), 0);
        check("ilv.delta_min", 32'(bus_a.delta_min), 1);
        check("ilv.delta_max", 32'(bus_a.delta_max), 1);

        // Two src fields in one window.
        s_tog = ~s_tog;
        tick(2);
        s_tog = ~s_tog;
        tick(2);
        d_tog = ~d_tog;
        tick(6);
        check("extra.slip_cnt",  32'(bus_a.slip_cnt), 1);
        check("extra.delta_max", 32'(bus_a.delta_max), 2);
        check("extra.delta_min", 32'(bus_a.delta_min), 1);

        // Counter wrap on the 4-bit instance.
        resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(5);
        for (int i = 0; i < 16; i++) begin
            s_tog = ~s_tog;
            tick(1);
        end
        tick(2);
        check("wrap.b_src_cnt", 32'(bus_b.src_cnt), 0);
        check("wrap.a_src_cnt", 32'(bus_a.src_cnt), 16);
        s_tog = ~s_tog;
        tick(2);
        check("wrap.b_src_cnt1", 32'(bus_b.src_cnt), 1);
        check("wrap.b_delta",    32'(bus_b.delta), 1);
        check("wrap.a_delta",    32'(bus_a.delta), 17);
        d_tog = ~d_tog;
        tick(5);
        check("wrap.b_delta0",   32'(bus_b.delta), 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) s_tog = ~s_tog;
            if ($urandom_range(0, 5) == 0) d_tog = ~d_tog;
            ev  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            clr = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        clr = 1'b0;
        ev = '0;
        tick(2);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
